// File: rtl/bus_pkg.sv
// Shared constants for the bus source multiplexer: default sizes, fixed source indices, counter width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bus_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NSRC_DEF  = 24;
  localparam int CNT_W     = 8;

  // Fixed source positions on the internal bus
  localparam int R0     = 0;
  localparam int R1     = 1;
  localparam int R2     = 2;
  localparam int R3     = 3;
  localparam int R4     = 4;
  localparam int R5     = 5;
  localparam int R6     = 6;
  localparam int R7     = 7;
  localparam int R8     = 8;
  localparam int R9     = 9;
  localparam int R10    = 10;
  localparam int R11    = 11;
  localparam int R12    = 12;
  localparam int R13    = 13;
  localparam int R14    = 14;
  localparam int R15    = 15;
  localparam int HI     = 16;
  localparam int LO     = 17;
  localparam int ZHI    = 18;
  localparam int ZLO    = 19;
  localparam int PC     = 20;
  localparam int MDR    = 21;
  localparam int INPORT = 22;
  localparam int CSIGN  = 23;

endpackage

// File: rtl/bus_prio_enc.sv
// Priority encoder over drive requests: lowest set index wins, flags any/multiple requests.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module bus_prio_enc
  import bus_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  localparam int SEL_W = $clog2(NSRC)
) (
  input  logic [NSRC-1:0]  src_out,
  output logic [SEL_W-1:0] index,
  output logic             any_req,
  output logic             multi
);

  // Scan high to low so the last hit (lowest index) is the one kept;
  // a hit while another was already seen marks a multi-drive.
  always_comb begin
    index   = '0;
    any_req = 1'b0;
    multi   = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_out[i]) begin
        multi   = multi | any_req;
        any_req = 1'b1;
        index   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_mux_pipe.sv
// Registered bus multiplexer: captures the winning source word, flags multi-drive conflicts (BUS_CONFLICT_CNT_EN adds a saturating conflict counter).
// Latency: one clock from src_out/src_data to bus outputs.
// Backpressure: stall=1 freezes the output stage and suppresses capture and conflict detection.
module bus_mux_pipe
  import bus_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int NSRC      = NSRC_DEF,
  parameter int HOLD_IDLE = 0,
  localparam int SEL_W    = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_out,
  input  logic                  stall,
  input  logic                  clr_sticky,
  output logic [WIDTH-1:0]      bus_data,
  output logic                  bus_valid,
  output logic [SEL_W-1:0]      bus_sel,
  output logic                  conflict,
  output logic                  conflict_sticky
`ifdef BUS_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0]      conflict_cnt
`endif
);

  logic [SEL_W-1:0] winIdx;
  logic             anyReq;
  logic             multiReq;
  logic [WIDTH-1:0] winWord;
  logic             confEvent;

  bus_prio_enc #(.NSRC(NSRC)) uEnc (
    .src_out (src_out),
    .index   (winIdx),
    .any_req (anyReq),
    .multi   (multiReq)
  );

  // A conflict only counts on a cycle where the output stage actually advances.
  assign confEvent = multiReq & ~stall;

  // Pick the winner's word out of the flattened source bus; indices past NSRC-1 never match.
  always_comb begin
    winWord = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (winIdx == SEL_W'(i)) winWord = src_data[i*WIDTH +: WIDTH];
    end
  end

  // Output stage: capture on request, clear (or hold data) on idle, freeze on stall.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bus_data  <= '0;
      bus_valid <= 1'b0;
      bus_sel   <= '0;
      conflict  <= 1'b0;
    end else if (!stall) begin
      conflict  <= multiReq;
      bus_valid <= anyReq;
      if (anyReq) begin
        bus_data <= winWord;
        bus_sel  <= winIdx;
      end else begin
        bus_sel <= '0;
        if (HOLD_IDLE == 0) bus_data <= '0;
      end
    end
  end

  // Sticky conflict flag; a new conflict wins over a same-cycle clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)          conflict_sticky <= 1'b0;
    else if (confEvent)  conflict_sticky <= 1'b1;
    else if (clr_sticky) conflict_sticky <= 1'b0;
  end

`ifdef BUS_CONFLICT_CNT_EN
  // Saturating conflict event counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                            conflict_cnt <= '0;
    else if (clr_sticky)                   conflict_cnt <= '0;
    else if (confEvent && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_bus_mux_pipe.sv
// Testbench for bus_mux_pipe: table vectors, directed corner sequences and randomized traffic vs a reference model.
// Latency: expects outputs one clock after inputs.
// Backpressure: exercises stall freezing and sticky/counter clears.
module tb_bus_mux_pipe;
  import bus_pkg::*;

  localparam int W = 32;
  localparam int N = 24;

  logic          clk;
  logic          clrN;
  logic [N-1:0]  srcOut;
  logic          stall;
  logic          clrSticky;
  logic [N*W-1:0] srcData;
  logic [W-1:0]  words [N];

  logic [W-1:0]  busData,  busDataH;
  logic          busValid, busValidH;
  logic [4:0]    busSel,   busSelH;
  logic          conflict, conflictH;
  logic          sticky,   stickyH;
`ifdef BUS_CONFLICT_CNT_EN
  logic [7:0]    cnt, cntH;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [W-1:0] mData, mDataH;
  logic         mValid, mConf, mSticky;
  logic [4:0]   mSel;
  int           mCnt;

  for (genvar g = 0; g < N; g++) begin : gPack
    assign srcData[g*W +: W] = words[g];
  end

  bus_mux_pipe #(.WIDTH(W), .NSRC(N), .HOLD_IDLE(0)) dut (
    .clk(clk), .clr_n(clrN), .src_data(srcData), .src_out(srcOut), .stall(stall),
    .clr_sticky(clrSticky), .bus_data(busData), .bus_valid(busValid), .bus_sel(busSel),
    .conflict(conflict), .conflict_sticky(sticky)
`ifdef BUS_CONFLICT_CNT_EN
    , .conflict_cnt(cnt)
`endif
  );

  bus_mux_pipe #(.WIDTH(W), .NSRC(N), .HOLD_IDLE(1)) dutH (
    .clk(clk), .clr_n(clrN), .src_data(srcData), .src_out(srcOut), .stall(stall),
    .clr_sticky(clrSticky), .bus_data(busDataH), .bus_valid(busValidH), .bus_sel(busSelH),
    .conflict(conflictH), .conflict_sticky(stickyH)
`ifdef BUS_CONFLICT_CNT_EN
    , .conflict_cnt(cntH)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic modelReset();
    mData = '0; mDataH = '0; mValid = 1'b0; mSel = '0; mConf = 1'b0; mSticky = 1'b0; mCnt = 0;
  endtask

  // Behaviour at one rising edge, from the rules: lowest requester wins, popcount>1 is a conflict.
  task automatic modelEdge();
    logic [N-1:0] low;
    int n;
    if (!clrN) begin
      modelReset();
      return;
    end
    n = $countones(srcOut);
    if (!stall) begin
      if (n > 0) begin
        low    = srcOut & (~srcOut + 1'b1);
        mSel   = 5'($countones(low - 1'b1));
        mData  = words[mSel];
        mDataH = words[mSel];
        mValid = 1'b1;
      end else begin
        mSel   = '0;
        mValid = 1'b0;
        mData  = '0;
      end
      mConf = (n > 1);
    end
    if (!stall && n > 1) mSticky = 1'b1;
    else if (clrSticky)  mSticky = 1'b0;
    if (clrSticky) mCnt = 0;
    else if (!stall && n > 1 && mCnt < 255) mCnt++;
  endtask

  task automatic cmpModel();
    chk("model bus_data",   busData,   mData);
    chk("model bus_valid",  busValid,  mValid);
    chk("model bus_sel",    busSel,    mSel);
    chk("model conflict",   conflict,  mConf);
    chk("model sticky",     sticky,    mSticky);
    chk("model hold data",  busDataH,  mDataH);
    chk("model hold valid", busValidH, mValid);
`ifdef BUS_CONFLICT_CNT_EN
    chk("model cnt",        cnt,       mCnt);
    chk("model hold cnt",   cntH,      mCnt);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    cmpModel();
  endtask

  typedef struct {
    logic [N-1:0] srcOut;
    logic         stall;
    logic [4:0]   sel;
    logic         valid;
    logic         conf;
    logic         sticky;
    logic [31:0]  data;
    logic [31:0]  dataH;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{24'h100000, 1'b0, 5'd20, 1'b1, 1'b0, 1'b0, 32'h5A00_0014, 32'h5A00_0014};
    vecs[1] = '{24'h200008, 1'b0, 5'd3,  1'b1, 1'b1, 1'b1, 32'h5A00_0003, 32'h5A00_0003};
    vecs[2] = '{24'h000000, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h5A00_0003};
    vecs[3] = '{24'h800000, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h5A00_0003};
    vecs[4] = '{24'h800000, 1'b0, 5'd23, 1'b1, 1'b0, 1'b1, 32'h5A00_0017, 32'h5A00_0017};
    vecs[5] = '{24'h000003, 1'b1, 5'd23, 1'b1, 1'b0, 1'b1, 32'h5A00_0017, 32'h5A00_0017};
    vecs[6] = '{24'hFFFFFF, 1'b0, 5'd0,  1'b1, 1'b1, 1'b1, 32'h5A00_0000, 32'h5A00_0000};
    vecs[7] = '{24'h400000, 1'b0, 5'd22, 1'b1, 1'b0, 1'b1, 32'h5A00_0016, 32'h5A00_0016};
    vecs[8] = '{24'h000001, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 32'h5A00_0000, 32'h5A00_0000};

    // Reset state
    clrN = 1'b0; srcOut = '0; stall = 1'b0; clrSticky = 1'b0;
    for (int i = 0; i < N; i++) words[i] = 32'h5A00_0000 + 32'(i);
    modelReset();
    #1;
    cmpModel();
    repeat (2) @(posedge clk);
    #1;
    clrN = 1'b1;

    // Table vectors
    for (int v = 0; v < 9; v++) begin
      srcOut = vecs[v].srcOut;
      stall  = vecs[v].stall;
      step();
      chk($sformatf("vec%0d sel", v),    busSel,    vecs[v].sel);
      chk($sformatf("vec%0d valid", v),  busValid,  vecs[v].valid);
      chk($sformatf("vec%0d conf", v),   conflict,  vecs[v].conf);
      chk($sformatf("vec%0d sticky", v), sticky,    vecs[v].sticky);
      chk($sformatf("vec%0d data", v),   busData,   vecs[v].data);
      chk($sformatf("vec%0d dataH", v),  busDataH,  vecs[v].dataH);
    end
    stall = 1'b0;
    clrSticky = 1'b1;
    step();
    clrSticky = 1'b0;

    // Single source: PC
    words[PC] = 32'h0000_0104;
    srcOut = 24'd1 << PC;
    step();
    chk("pc data", busData, 32'h0000_0104);
    chk("pc sel", busSel, 32'd20);
    chk("pc valid", busValid, 1'b1);
    chk("pc conflict", conflict, 1'b0);

    // Asynchronous reset mid-cycle while PC is driving
    #2;
    clrN = 1'b0;
    #1;
    modelReset();
    chk("arst data", busData, 32'd0);
    chk("arst valid", busValid, 1'b0);
    chk("arst sel", busSel, 32'd0);
    chk("arst sticky", sticky, 1'b0);
    step();
    clrN = 1'b1;
    step();
    chk("post-reset capture valid", busValid, 1'b1);
    chk("post-reset capture sel", busSel, 32'd20);

    // Conflict between R3 and MDR
    words[R3] = 32'hAAAA_0003;
    srcOut = (24'd1 << R3) | (24'd1 << MDR);
    step();
    chk("conf data", busData, 32'hAAAA_0003);
    chk("conf sel", busSel, 32'd3);
    chk("conf flag", conflict, 1'b1);
    chk("conf sticky", sticky, 1'b1);
    srcOut = 24'd1 << R5;
    step();
    chk("conf one-cycle", conflict, 1'b0);
    repeat (2) step();
    chk("sticky holds", sticky, 1'b1);
    clrSticky = 1'b1;
    step();
    chk("sticky cleared", sticky, 1'b0);
    srcOut = (24'd1 << R3) | (24'd1 << MDR);
    step();
    chk("set beats clear", sticky, 1'b1);
    clrSticky = 1'b0;

    // Stall freezes outputs while requests change
    words[MDR] = 32'h1234_5678;
    srcOut = 24'd1 << MDR;
    step();
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      srcOut = (24'd1 << (c + 1)) | 24'h800000;
      words[MDR] = 32'h0BAD_0000 + 32'(c);
      step();
      chk("stall data", busData, 32'h1234_5678);
      chk("stall sel", busSel, 32'd21);
      chk("stall conflict", conflict, 1'b0);
    end
    stall = 1'b0;
    words[INPORT] = 32'hCAFE_0022;
    srcOut = 24'd1 << INPORT;
    step();
    chk("unstall data", busData, 32'hCAFE_0022);

    // Idle after a capture
    words[ZLO] = 32'hDEAD_BEEF;
    srcOut = 24'd1 << ZLO;
    step();
    srcOut = '0;
    step();
    chk("idle data", busData, 32'd0);
    chk("idle valid", busValid, 1'b0);
    chk("idle hold data", busDataH, 32'hDEAD_BEEF);
    chk("idle hold valid", busValidH, 1'b0);

`ifdef BUS_CONFLICT_CNT_EN
    // Counter saturation and clear-beats-increment
    clrSticky = 1'b1;
    step();
    clrSticky = 1'b0;
    srcOut = 24'h000003;
    for (int c = 0; c < 260; c++) step();
    chk("cnt saturate", cnt, 32'd255);
    clrSticky = 1'b1;
    step();
    chk("cnt cleared", cnt, 32'd0);
    chk("cnt sticky set", sticky, 1'b1);
    clrSticky = 1'b0;
`endif

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) words[i] = $urandom;
      case ($urandom_range(0, 3))
        0:       srcOut = '0;
        1:       srcOut = 24'd1 << $urandom_range(0, N - 1);
        default: srcOut = 24'($urandom);
      endcase
      stall     = ($urandom_range(0, 3) == 0);
      clrSticky = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_mux_pipe.md
BUS_MUX_PIPE -- requirements
Module: bus_mux_pipe

Interface
REQ-001 Parameter WIDTH, default 32: bit width of every source word and of the bus.
REQ-002 Parameter NSRC, default 24: number of bus sources; legal range 2..32.
REQ-003 Parameter HOLD_IDLE, default 0: 0 drives zero on an idle cycle, 1 holds the last bus word on an idle cycle.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 clr_n  input  1  asynchronous, active-low reset.
REQ-006 src_data  input  NSRC*WIDTH  flattened source words; source i occupies bits [i*WIDTH +: WIDTH].
REQ-007 src_out  input  NSRC  one-hot drive requests, one per source (R0out..Cout style).
REQ-008 stall  input  1  when high, the output stage holds and no new word is captured.
REQ-009 bus_data  output  WIDTH  registered bus word.
REQ-010 bus_valid  output  1  high when bus_data holds a word captured from a driving source.
REQ-011 bus_sel  output  SEL_W  registered binary index of the source captured; SEL_W = clog2(NSRC).
REQ-012 conflict  output  1  registered; high for one cycle after a capture cycle with more than one src_out bit set.
REQ-013 conflict_sticky  output  1  set by any conflict, cleared only by reset or clr_sticky.
REQ-014 clr_sticky  input  1  synchronous clear of conflict_sticky (and of conflict_cnt when compiled in).

Function
REQ-015 Encoder: combinational priority encode of src_out; lowest set index wins; any_req = OR of src_out.
REQ-016 Latency: exactly one clock from src_out/src_data to bus_data/bus_valid/bus_sel.
REQ-017 Capture cycle (stall=0, any_req=1): bus_data <= src_data[winner], bus_sel <= winner, bus_valid <= 1.
REQ-018 Idle cycle (stall=0, any_req=0): bus_valid <= 0, bus_sel <= 0; bus_data <= 0 if HOLD_IDLE=0, else unchanged.
REQ-019 Stall cycle (stall=1): bus_data, bus_valid, bus_sel, conflict unchanged regardless of src_out; conflict_sticky not set.
REQ-020 Conflict: popcount(src_out) > 1 on a non-stall cycle sets conflict for the next cycle and sets conflict_sticky; winner still per REQ-015.
REQ-021 clr_sticky and a new conflict in the same cycle: sticky ends set (set dominates).
REQ-022 Source index >= NSRC is unreachable; bus_sel never exceeds NSRC-1.
REQ-023 No combinational path from any input to any output.

Reset
REQ-024 clr_n low asynchronously forces bus_data=0, bus_valid=0, bus_sel=0, conflict=0, conflict_sticky=0, conflict_cnt=0.
REQ-025 Reset mid-capture discards the word; first capture after clr_n rises occurs on the first rising edge with clr_n high.

Configuration
REQ-026 Macro BUS_CONFLICT_CNT_EN defined: extra output conflict_cnt (8 bits) increments on each conflict event, saturates at 255, clears on reset or clr_sticky (clear dominates increment).
REQ-027 Macro BUS_CONFLICT_CNT_EN undefined: no conflict_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-028 Shared package bus_pkg holds: default WIDTH/NSRC constants, the fixed source-index constants (R0..R15=0..15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, INPORT=22, CSIGN=23), and the conflict_cnt width constant.
REQ-029 One sub-module, bus_prio_enc (parametrised NSRC, outputs index, any_req, multi), instantiated once; the register stage stays in bus_mux_pipe.

Verification
REQ-030 Reset: clr_n low mid-simulation with src_out=1<<20 -> all outputs 0 immediately, before the next clk edge.
REQ-031 Single source: src_out=1<<20, PC word 0x0000_0104 -> next cycle bus_data=0x0000_0104, bus_sel=20, bus_valid=1, conflict=0.
REQ-032 Conflict: src_out bits 3 and 21 set, R3=0xAAAA_0003 -> bus_data=0xAAAA_0003, bus_sel=3, conflict=1 for one cycle, conflict_sticky=1 until clr_sticky pulse.
REQ-033 Stall: capture 0x1234_5678, then stall=1 for 3 cycles while src_out changes -> outputs frozen; stall=0 -> new word one cycle later.
REQ-034 Idle: src_out=0 after capture of 0xDEAD_BEEF -> HOLD_IDLE=0 gives bus_data=0, bus_valid=0; HOLD_IDLE=1 gives bus_data=0xDEAD_BEEF, bus_valid=0.
REQ-035 Counter (BUS_CONFLICT_CNT_EN): 260 consecutive conflict cycles -> conflict_cnt=255; clr_sticky with conflict same cycle -> conflict_cnt=0, conflict_sticky=1.
